// File: rtl/preproc.sv
// Input-side pre-processor for the FFT/IFFT core: strips CP, buffers one symbol per ping-pong bank, bursts it out.
// Optional macro PREPROC_OVF_CNT_EN enables the saturating dropped-symbol counter on ovf_cnt.

`ifndef BUF_ADDR_NBIT
`define BUF_ADDR_NBIT 11
`endif
`ifndef FFT_NUM_NBIT
`define FFT_NUM_NBIT 12
`endif
`ifndef FFT_MAX_NUM
`define FFT_MAX_NUM 2048
`endif
`ifndef CP_NOR_FST_NUM
`define CP_NOR_FST_NUM 160
`endif
`ifndef CP_NOR_NUM
`define CP_NOR_NUM 144
`endif
`ifndef CP_EXT_NUM
`define CP_EXT_NUM 512
`endif

module preproc #(
    parameter int DATA_NBIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fft_type,
    input  logic                 cp_type,
    input  logic [2:0]           fft_num,
    input  logic                 din_h,
    input  logic                 din_s,
    input  logic                 din_v,
    input  logic [DATA_NBIT-1:0] din_i,
    input  logic [DATA_NBIT-1:0] din_q,
    input  logic                 dout_ready,
    output logic                 dout_sop,
    output logic                 dout_eop,
    output logic                 dout_valid,
    output logic [DATA_NBIT-1:0] dout_real,
    output logic [DATA_NBIT-1:0] dout_imag,
    output logic                 dout_fst,
    output logic                 ovf,
    output logic [15:0]          ovf_cnt
);
    localparam int NB = `FFT_NUM_NBIT;
    localparam int BA = `BUF_ADDR_NBIT;
    localparam int EW = 2*DATA_NBIT + 3;

    typedef enum logic [1:0] {W_IDLE, W_SKIP, W_FILL} wstate_t;
    typedef enum logic {R_IDLE, R_BURST} rstate_t;

    wstate_t wstate, wnext;
    rstate_t rstate, rnext;

    logic [NB-1:0] cfg_n, cfg_cp, cur_n, cur_cp, wcnt, wcnt_next;
    logic          cur_fst, wbank, latch, ram_we, mark_full, ovf_next;
    logic [BA-1:0] wr_addr_lo;

    logic [1:0]    bank_full, bank_rdy;
    logic [NB-1:0] bank_n [2];
    logic          bank_fst [2];
    logic          fptr;

    logic [2*DATA_NBIT-1:0] mem [0:2**(BA+1)-1];
    logic [2*DATA_NBIT-1:0] rdata;

    logic [NB-1:0] rcnt, rn;
    logic          rbank, rfst, issue, load, load_bank, last, can_issue;
    logic          rd_valid, rd_sop, rd_eop, rd_fst;

    logic [EW-1:0] head, tail, new_entry;
    logic [1:0]    fcnt;
    logic [2:0]    occ;
    logic          push, pop, free;

    // Symbol geometry for the symbol whose header is on the input right now.
    always_comb begin
        cfg_n = NB'(`FFT_MAX_NUM >> fft_num);
        if (fft_type)
            cfg_cp = '0;
        else if (cp_type)
            cfg_cp = NB'(`CP_EXT_NUM >> fft_num);
        else
            cfg_cp = NB'((din_s ? `CP_NOR_FST_NUM : `CP_NOR_NUM) >> fft_num);
    end

    // A header always wins: it either restarts the symbol in the current bank or is dropped as an overflow.
    always_comb begin
        wnext      = wstate;
        wcnt_next  = wcnt;
        wr_addr_lo = wcnt[BA-1:0];
        latch      = 1'b0;
        ram_we     = 1'b0;
        mark_full  = 1'b0;
        ovf_next   = 1'b0;
        if (din_h && din_v) begin
            if (bank_full[wbank]) begin
                ovf_next = 1'b1;
                wnext    = W_IDLE;
            end else begin
                latch = 1'b1;
                if (cfg_cp == '0) begin
                    ram_we     = 1'b1;
                    wr_addr_lo = '0;
                    wcnt_next  = NB'(1);
                    wnext      = W_FILL;
                end else if (cfg_cp == NB'(1)) begin
                    wcnt_next = '0;
                    wnext     = W_FILL;
                end else begin
                    wcnt_next = NB'(1);
                    wnext     = W_SKIP;
                end
            end
        end else if (din_v) begin
            case (wstate)
                W_SKIP: begin
                    if (wcnt == cur_cp - 1'b1) begin
                        wcnt_next = '0;
                        wnext     = W_FILL;
                    end else begin
                        wcnt_next = wcnt + 1'b1;
                    end
                end
                W_FILL: begin
                    ram_we = 1'b1;
                    if (wcnt == cur_n - 1'b1) begin
                        mark_full = 1'b1;
                        wcnt_next = '0;
                        wnext     = W_IDLE;
                    end else begin
                        wcnt_next = wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate  <= W_IDLE;
            wcnt    <= '0;
            cur_n   <= '0;
            cur_cp  <= '0;
            cur_fst <= 1'b0;
            wbank   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            wstate <= wnext;
            wcnt   <= wcnt_next;
            ovf    <= ovf_next;
            if (latch) begin
                cur_n   <= cfg_n;
                cur_cp  <= cfg_cp;
                cur_fst <= din_s;
            end
            if (mark_full)
                wbank <= ~wbank;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[{wbank, wr_addr_lo}] <= {din_i, din_q};
        if (issue)
            rdata <= mem[{rbank, rcnt[BA-1:0]}];
    end

    // bank_rdy means "full and not yet started"; bank_full stays set until the eop beat leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full   <= '0;
            bank_rdy    <= '0;
            bank_n[0]   <= '0;
            bank_n[1]   <= '0;
            bank_fst[0] <= 1'b0;
            bank_fst[1] <= 1'b0;
            fptr        <= 1'b0;
        end else begin
            if (mark_full) begin
                bank_full[wbank] <= 1'b1;
                bank_rdy[wbank]  <= 1'b1;
                bank_n[wbank]    <= cur_n;
                bank_fst[wbank]  <= cur_fst;
            end
            if (load)
                bank_rdy[load_bank] <= 1'b0;
            if (free) begin
                bank_full[fptr] <= 1'b0;
                fptr            <= ~fptr;
            end
        end
    end

    assign pop       = dout_valid & dout_ready;
    assign occ       = {1'b0, fcnt} + {2'b0, rd_valid} - {2'b0, pop};
    assign can_issue = (occ < 3'd2);
    assign last      = (rcnt == rn - 1'b1);

    // Reads are only issued when the skid buffer is guaranteed a slot for the returning word.
    always_comb begin
        rnext     = rstate;
        issue     = 1'b0;
        load      = 1'b0;
        load_bank = rbank;
        case (rstate)
            R_IDLE: begin
                if (bank_rdy[rbank]) begin
                    load  = 1'b1;
                    rnext = R_BURST;
                end
            end
            R_BURST: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (last) begin
                        load_bank = ~rbank;
                        if (bank_rdy[~rbank])
                            load = 1'b1;
                        else
                            rnext = R_IDLE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate   <= R_IDLE;
            rbank    <= 1'b0;
            rcnt     <= '0;
            rn       <= '0;
            rfst     <= 1'b0;
            rd_valid <= 1'b0;
            rd_sop   <= 1'b0;
            rd_eop   <= 1'b0;
            rd_fst   <= 1'b0;
        end else begin
            rstate   <= rnext;
            rd_valid <= issue;
            if (issue) begin
                rd_sop <= (rcnt == '0);
                rd_eop <= last;
                rd_fst <= rfst;
                rcnt   <= rcnt + 1'b1;
                if (last)
                    rbank <= ~rbank;
            end
            if (load) begin
                rn   <= bank_n[load_bank];
                rfst <= bank_fst[load_bank];
                rcnt <= '0;
            end
        end
    end

    assign push      = rd_valid;
    assign new_entry = {rd_sop, rd_eop, rd_fst, rdata};
    assign free      = pop & head[EW-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            fcnt <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fcnt == 2'd0)
                        head <= new_entry;
                    else
                        tail <= new_entry;
                    fcnt <= fcnt + 1'b1;
                end
                2'b01: begin
                    head <= tail;
                    fcnt <= fcnt - 1'b1;
                end
                2'b11: begin
                    if (fcnt == 2'd1) begin
                        head <= new_entry;
                    end else begin
                        head <= tail;
                        tail <= new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_valid = (fcnt != 2'd0);
    assign dout_sop   = head[EW-1];
    assign dout_eop   = head[EW-2];
    assign dout_fst   = head[EW-3];
    assign dout_real  = head[2*DATA_NBIT-1:DATA_NBIT];
    assign dout_imag  = head[DATA_NBIT-1:0];

`ifdef PREPROC_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            ovf_cnt <= '0;
        else if (ovf && ovf_cnt != 16'hFFFF)
            ovf_cnt <= ovf_cnt + 1'b1;
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule
